// File: rtl/multi_ch_window_shift.sv
// multi_ch_window_shift: per-channel sliding window of the last DEPTH samples.
// Each accepted sample shifts into its channel's window. The post-update window
// of that channel is then presented one cycle later. out_valid pulses once the
// channel holds DEPTH samples.
// Build option: define WINDOW_SUM_EN to keep a running signed window sum per
// channel on out_sum. Without it, out_sum is tied to zero.
module multi_ch_window_shift #(
    parameter int WIDTH    = 37,
    parameter int DEPTH    = 6,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int SUM_W    = WIDTH + $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_n,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [CH_W-1:0]        in_ch,
    input  logic [WIDTH-1:0]       din,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_ch,
    output logic [DEPTH*WIDTH-1:0] out_taps,
    output logic [SUM_W-1:0]       out_sum,
    output logic [CHANNELS-1:0]    ch_full,
    output logic                   err
);

    localparam int                FILL_W   = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);
    localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic [WIDTH-1:0]       win  [CHANNELS][DEPTH];
    logic [FILL_W-1:0]      fill [CHANNELS];

    logic                   do_clear;
    logic                   sample;
    logic                   in_range;
    logic                   accept;
    logic                   bad;
    logic [WIDTH-1:0]       sel_win [DEPTH-1];
    logic [FILL_W-1:0]      sel_fill;
    logic [FILL_W-1:0]      fill_next;
    logic [DEPTH*WIDTH-1:0] new_taps;

    // A sample qualifies only when enabled, not clearing, and the index is in range.
    always_comb begin
        do_clear = ~en_n & clear;
        sample   = ~en_n & ~clear & in_valid;
        in_range = ({1'b0, in_ch} < CH_LIMIT);
        accept   = sample & in_range;
        bad      = sample & ~in_range;
    end

    // Pick the addressed channel's window and fill count, and build its post-shift window.
    always_comb begin
        sel_fill = '0;
        for (int k = 0; k < DEPTH - 1; k++) sel_win[k] = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_ch == CH_W'(c)) begin
                sel_fill = fill[c];
                for (int k = 0; k < DEPTH - 1; k++) sel_win[k] = win[c][k];
            end
        end
        fill_next = (sel_fill == FILL_MAX) ? FILL_MAX : sel_fill + 1'b1;
        new_taps  = '0;
        new_taps[WIDTH-1:0] = din;
        for (int k = 1; k < DEPTH; k++) new_taps[k*WIDTH +: WIDTH] = sel_win[k-1];
    end

    // A channel is full once it has seen DEPTH accepts since the last rst/clear.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) ch_full[c] = (fill[c] == FILL_MAX);
    end

    // Window shift, fill tracking, error flag and the registered presentation outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_taps  <= '0;
            err       <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                fill[c] <= '0;
                for (int k = 0; k < DEPTH; k++) win[c][k] <= '0;
            end
        end else begin
            out_valid <= accept && (fill_next == FILL_MAX);
            if (do_clear) begin
                err <= 1'b0;
                for (int c = 0; c < CHANNELS; c++) begin
                    fill[c] <= '0;
                    for (int k = 0; k < DEPTH; k++) win[c][k] <= '0;
                end
            end else begin
                if (bad) err <= 1'b1;
                if (accept) begin
                    out_ch   <= in_ch;
                    out_taps <= new_taps;
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (in_ch == CH_W'(c)) begin
                            fill[c]   <= fill_next;
                            win[c][0] <= din;
                            for (int k = 1; k < DEPTH; k++) win[c][k] <= win[c][k-1];
                        end
                    end
                end
            end
        end
    end

`ifdef WINDOW_SUM_EN
    logic signed [SUM_W-1:0] sum_r [CHANNELS];
    logic signed [SUM_W-1:0] sel_sum;
    logic signed [SUM_W-1:0] din_x;
    logic signed [SUM_W-1:0] old_x;
    logic signed [SUM_W-1:0] sum_next;

    // Running sum: add the newcomer and drop the sample falling off the window.
    // The final value always fits SUM_W, so any intermediate wrap cancels out.
    always_comb begin
        sel_sum = '0;
        old_x   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_ch == CH_W'(c)) begin
                sel_sum = sum_r[c];
                old_x   = {{(SUM_W-WIDTH){win[c][DEPTH-1][WIDTH-1]}}, win[c][DEPTH-1]};
            end
        end
        din_x    = {{(SUM_W-WIDTH){din[WIDTH-1]}}, din};
        sum_next = sel_sum + din_x - old_x;
    end

    // Per-channel sum registers and the presented sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum <= '0;
            for (int c = 0; c < CHANNELS; c++) sum_r[c] <= '0;
        end else if (do_clear) begin
            for (int c = 0; c < CHANNELS; c++) sum_r[c] <= '0;
        end else if (accept) begin
            out_sum <= sum_next;
            for (int c = 0; c < CHANNELS; c++) begin
                if (in_ch == CH_W'(c)) sum_r[c] <= sum_next;
            end
        end
    end
`else
    assign out_sum = '0;
`endif

endmodule

// File: tb/tb_multi_ch_window_shift.sv
// Bench for multi_ch_window_shift: a 4-channel and a 3-channel instance share
// one stimulus stream. A queue-based history model predicts every output on
// every cycle, and literal checks pin the hand-derived values.
module tb_multi_ch_window_shift;
    localparam int WIDTH = 37;
    localparam int DEPTH = 6;
    localparam int CH_W  = 2;
    localparam int SUM_W = WIDTH + $clog2(DEPTH);
    localparam longint MAXP = (64'sd1 <<< (WIDTH - 1)) - 1;
    localparam longint MAXN = -(64'sd1 <<< (WIDTH - 1));
`ifdef WINDOW_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, en_n, clear, in_valid;
    logic [CH_W-1:0] in_ch;
    logic [WIDTH-1:0] din;

    logic a_out_valid, b_out_valid, a_err, b_err;
    logic [CH_W-1:0] a_out_ch, b_out_ch;
    logic [DEPTH*WIDTH-1:0] a_out_taps, b_out_taps;
    logic [SUM_W-1:0] a_out_sum, b_out_sum;
    logic [3:0] a_ch_full;
    logic [2:0] b_ch_full;

    int n_checks = 0;
    int n_errors = 0;

    multi_ch_window_shift #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(4)) dut_a (
        .clk(clk), .rst(rst), .en_n(en_n), .clear(clear), .in_valid(in_valid),
        .in_ch(in_ch), .din(din), .out_valid(a_out_valid), .out_ch(a_out_ch),
        .out_taps(a_out_taps), .out_sum(a_out_sum), .ch_full(a_ch_full), .err(a_err));

    multi_ch_window_shift #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(3)) dut_b (
        .clk(clk), .rst(rst), .en_n(en_n), .clear(clear), .in_valid(in_valid),
        .in_ch(in_ch), .din(din), .out_valid(b_out_valid), .out_ch(b_out_ch),
        .out_taps(b_out_taps), .out_sum(b_out_sum), .ch_full(b_ch_full), .err(b_err));

    always #5 clk = ~clk;

    // Model state: per instance, per channel, the most recent samples (newest first).
    longint hist [2][4][$];
    logic   ev   [2];
    logic [CH_W-1:0] ech [2];
    longint etaps [2][DEPTH];
    longint esum [2];
    logic [3:0] efull [2];
    logic   eerr [2];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic e, input logic cl,
                              input logic v, input logic [CH_W-1:0] ch, input longint d);
        int n;
        longint s;
        n = (i == 0) ? 4 : 3;
        if (r) begin
            for (int c = 0; c < 4; c++) hist[i][c].delete();
            ev[i] = 1'b0; ech[i] = '0; esum[i] = 0; eerr[i] = 1'b0;
            for (int k = 0; k < DEPTH; k++) etaps[i][k] = 0;
        end else if (e) begin
            ev[i] = 1'b0;
        end else if (cl) begin
            for (int c = 0; c < 4; c++) hist[i][c].delete();
            ev[i] = 1'b0; eerr[i] = 1'b0;
        end else if (v) begin
            if (int'(ch) < n) begin
                hist[i][ch].push_front(d);
                if (hist[i][ch].size() > DEPTH) void'(hist[i][ch].pop_back());
                ev[i] = (hist[i][ch].size() == DEPTH);
                ech[i] = ch;
                s = 0;
                for (int k = 0; k < DEPTH; k++) begin
                    etaps[i][k] = (k < hist[i][ch].size()) ? hist[i][ch][k] : 0;
                    s += etaps[i][k];
                end
                esum[i] = SUM_ON ? s : 0;
            end else begin
                eerr[i] = 1'b1;
                ev[i] = 1'b0;
            end
        end else begin
            ev[i] = 1'b0;
        end
        for (int c = 0; c < 4; c++) efull[i][c] = (c < n) && (hist[i][c].size() == DEPTH);
    endtask

    // Update the model with the inputs seen at each edge, then compare both DUTs.
    always @(posedge clk) begin
        model_step(0, rst, en_n, clear, in_valid, in_ch, longint'($signed(din)));
        model_step(1, rst, en_n, clear, in_valid, in_ch, longint'($signed(din)));
        #1;
        chk("a_valid", a_out_valid, ev[0]);
        chk("a_ch", a_out_ch, ech[0]);
        chk("a_sum", $signed(a_out_sum), esum[0]);
        chk("a_full", a_ch_full, efull[0]);
        chk("a_err", a_err, eerr[0]);
        chk("b_valid", b_out_valid, ev[1]);
        chk("b_ch", b_out_ch, ech[1]);
        chk("b_sum", $signed(b_out_sum), esum[1]);
        chk("b_full", b_ch_full, efull[1][2:0]);
        chk("b_err", b_err, eerr[1]);
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("a_tap%0d", k), $signed(a_out_taps[k*WIDTH +: WIDTH]), etaps[0][k]);
            chk($sformatf("b_tap%0d", k), $signed(b_out_taps[k*WIDTH +: WIDTH]), etaps[1][k]);
        end
    end

    task automatic step(input logic v, input int ch, input longint d,
                        input logic e = 1'b0, input logic cl = 1'b0);
        @(negedge clk);
        in_valid = v; in_ch = CH_W'(ch); din = d[WIDTH-1:0]; en_n = e; clear = cl;
        @(posedge clk);
        #2;
    endtask

    function automatic longint a_tap(input int k);
        return $signed(a_out_taps[k*WIDTH +: WIDTH]);
    endfunction

    initial begin
        rst = 1'b1; en_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_ch = '0; din = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", a_out_valid, 0);
        chk("rst_full", a_ch_full, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill channel 2 with 1..7.
        for (int s = 1; s <= 7; s++) begin
            step(1'b1, 2, s);
            if (s == 5) chk("fill_no_valid5", a_out_valid, 0);
            if (s == 6) begin
                chk("fill_valid6", a_out_valid, 1);
                chk("fill_sum6", $signed(a_out_sum), SUM_ON ? 21 : 0);
                chk("fill_newest6", a_tap(0), 6);
                chk("fill_oldest6", a_tap(5), 1);
                chk("fill_full6", a_ch_full, 4'b0100);
            end
            if (s == 7) begin
                chk("fill_sum7", $signed(a_out_sum), SUM_ON ? 27 : 0);
                chk("fill_newest7", a_tap(0), 7);
                chk("fill_oldest7", a_tap(5), 2);
            end
        end

        // Interleave channels 0 and 1 with 10k and -10k.
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 0, 10 * k);
            if (k == 6) chk("il_ch0_sum", $signed(a_out_sum), SUM_ON ? 210 : 0);
            step(1'b1, 1, -10 * k);
        end
        chk("il_ch1_valid", a_out_valid, 1);
        chk("il_ch1_sum", $signed(a_out_sum), SUM_ON ? -210 : 0);
        chk("il_ch1_oldest", a_tap(5), -10);
        chk("il_full", a_ch_full, 4'b0111);

        // Hold with in_valid, then clear with in_valid, then five fresh samples.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 0, 999, 1'b1, 1'b0);
            chk("hold_no_valid", a_out_valid, 0);
        end
        chk("hold_full", a_ch_full, 4'b0111);
        step(1'b1, 0, 5, 1'b0, 1'b1);
        chk("clear_full", a_ch_full, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 0, k);
            chk("post_clear_no_valid", a_out_valid, 0);
        end

        // Bad index on the 3-channel instance.
        step(1'b1, 3, 77);
        chk("bad_err", b_err, 1);
        chk("bad_no_valid", b_out_valid, 0);
        step(1'b1, 0, 6);
        chk("bad_err_sticky", b_err, 1);
        chk("bad_ch0_valid", b_out_valid, 1);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        chk("bad_err_hold", b_err, 1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        chk("bad_err_cleared", b_err, 0);

        // Extremes: alternating full-scale, then all max positive, then all max negative.
        for (int k = 0; k < 8; k++) step(1'b1, 1, (k % 2 == 0) ? MAXP : MAXN);
        for (int k = 0; k < 6; k++) step(1'b1, 2, MAXP);
        chk("ext_sum_pos", $signed(a_out_sum), SUM_ON ? 6 * MAXP : 0);
        for (int k = 0; k < 6; k++) step(1'b1, 3, MAXN);
        chk("ext_sum_neg", $signed(a_out_sum), SUM_ON ? 6 * MAXN : 0);

        // Reset mid-stream with three channels full.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++)
            for (int c = 0; c < 3; c++) step(1'b1, c, 100 * c + k);
        chk("pre_rst_full", a_ch_full, 4'b0111);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("mrst_taps_zero", (a_out_taps == '0) ? 1 : 0, 1);
        chk("mrst_full", a_ch_full, 0);
        chk("mrst_sum", $signed(a_out_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 0, k);
            chk("mrst_refill_valid", a_out_valid, (k == 6) ? 1 : 0);
        end
        step(1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
